// File: rtl/ula_74181_serial.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ula_74181_serial                                            |
// | Purpose  : WIDTH-bit 74181-style ALU (16 arithmetic + 16 logic ops)    |
// |            evaluated one 4-bit slice per clock with a registered       |
// |            ripple carry, valid/ready handshake on both sides.          |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ula_74181_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] C_LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [3:0]        s_q, s_d;
  logic              m_q, m_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  f_q, f_d;
  logic              c_out_q, c_out_d;
  logic              eq_q, eq_d;

  logic [IDXW+1:0]   w_base;
  logic [3:0]        w_a_sl, w_b_sl;
  logic [3:0]        w_x, w_y, w_lg;
  logic [4:0]        w_sum;
  logic [3:0]        w_slice_f;
  logic              w_carry_nx;

  // One slice of the ALU: arithmetic ops reduce to x + y + carry, where x and
  // y are bitwise functions of A/B, so rippling the carry slice by slice is exact.
  always_comb begin
    w_base = {idx_q, 2'b00};
    w_a_sl = a_q[w_base +: 4];
    w_b_sl = b_q[w_base +: 4];
    w_x    = 4'h0;
    w_y    = 4'h0;
    w_lg   = 4'h0;
    case (s_q)
      4'b0000: begin w_x = w_a_sl;            w_y = 4'h0;             w_lg = ~w_a_sl;            end
      4'b0001: begin w_x = w_a_sl | w_b_sl;   w_y = 4'h0;             w_lg = ~(w_a_sl | w_b_sl); end
      4'b0010: begin w_x = w_a_sl | ~w_b_sl;  w_y = 4'h0;             w_lg = ~w_a_sl & w_b_sl;   end
      4'b0011: begin w_x = 4'hF;              w_y = 4'h0;             w_lg = 4'h0;               end
      4'b0100: begin w_x = w_a_sl;            w_y = w_a_sl & ~w_b_sl; w_lg = ~(w_a_sl & w_b_sl); end
      4'b0101: begin w_x = w_a_sl | w_b_sl;   w_y = w_a_sl & ~w_b_sl; w_lg = ~w_b_sl;            end
      // A - B - 1 is A + ~B in two's complement.
      4'b0110: begin w_x = w_a_sl;            w_y = ~w_b_sl;          w_lg = w_a_sl ^ w_b_sl;    end
      4'b0111: begin w_x = w_a_sl & ~w_b_sl;  w_y = 4'hF;             w_lg = w_a_sl & ~w_b_sl;   end
      4'b1000: begin w_x = w_a_sl;            w_y = w_a_sl & w_b_sl;  w_lg = ~w_a_sl | w_b_sl;  end
      4'b1001: begin w_x = w_a_sl;            w_y = w_b_sl;           w_lg = ~(w_a_sl ^ w_b_sl); end
      4'b1010: begin w_x = w_a_sl | ~w_b_sl;  w_y = w_a_sl & w_b_sl;  w_lg = w_b_sl;             end
      4'b1011: begin w_x = w_a_sl & w_b_sl;   w_y = 4'hF;             w_lg = w_a_sl & w_b_sl;    end
      4'b1100: begin w_x = w_a_sl;            w_y = w_a_sl;           w_lg = 4'hF;               end
      4'b1101: begin w_x = w_a_sl | w_b_sl;   w_y = w_a_sl;           w_lg = w_a_sl | ~w_b_sl;   end
      4'b1110: begin w_x = w_a_sl | ~w_b_sl;  w_y = w_a_sl;           w_lg = w_a_sl | w_b_sl;    end
      default: begin w_x = w_a_sl;            w_y = 4'hF;             w_lg = w_a_sl;             end
    endcase
    w_sum      = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, carry_q};
    w_slice_f  = m_q ? w_lg : w_sum[3:0];
    w_carry_nx = m_q ? 1'b0 : w_sum[4];
  end

  // Handshake FSM: latch operands, walk the slices, then hold the result.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    f_d     = f_q;
    c_out_d = c_out_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          carry_d = c_in;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d[w_base +: 4] = w_slice_f;
        carry_d            = w_carry_nx;
        if (idx_q == C_LAST) begin
          f_d     = acc_d;
          c_out_d = w_carry_nx;
          eq_d    = &acc_d;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      f_q     <= '0;
      c_out_q <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      f_q     <= f_d;
      c_out_q <= c_out_d;
      eq_q    <= eq_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign f         = f_q;
  assign c_out     = c_out_q;
  assign a_eq_b    = eq_q;

endmodule
`default_nettype wire

// File: tb/tb_ula_74181_serial.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_ula_74181_serial                                         |
// | Purpose  : Directed-vector bench for ula_74181_serial (WIDTH=16 and 8). |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_ula_74181_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, f;
  logic [3:0]  s;
  logic        m, c_in, c_out, a_eq_b;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, f8;
  logic [3:0]  s8;
  logic        m8, c_in8, c_out8, a_eq_b8;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ula_74181_serial #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .m(m), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .c_out(c_out), .a_eq_b(a_eq_b)
  );

  ula_74181_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .s(s8), .m(m8), .c_in(c_in8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .f(f8), .c_out(c_out8), .a_eq_b(a_eq_b8)
  );

  typedef struct {
    logic        m;
    logic [3:0]  s;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] ef;
    logic        ec;
    logic        eq;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Full-width reference: {c_out, f} straight from the function table.
  function automatic logic [16:0] ref16(input logic mm, input logic [3:0] ss,
                                        input logic [15:0] aa, input logic [15:0] bb,
                                        input logic cc);
    logic [16:0] ea, eb, nb, ab, anb, aob, aonb, ones, r;
    ea = {1'b0, aa}; eb = {1'b0, bb}; nb = {1'b0, ~bb};
    ab = {1'b0, aa & bb}; anb = {1'b0, aa & ~bb};
    aob = {1'b0, aa | bb}; aonb = {1'b0, aa | ~bb}; ones = 17'h0FFFF;
    if (!mm) begin
      case (ss)
        4'h0: r = ea;          4'h1: r = aob;         4'h2: r = aonb;        4'h3: r = ones;
        4'h4: r = ea + anb;    4'h5: r = aob + anb;   4'h6: r = ea + nb;     4'h7: r = anb + ones;
        4'h8: r = ea + ab;     4'h9: r = ea + eb;     4'hA: r = aonb + ab;   4'hB: r = ab + ones;
        4'hC: r = ea + ea;     4'hD: r = aob + ea;    4'hE: r = aonb + ea;   default: r = ea + ones;
      endcase
      r = r + {16'h0000, cc};
    end else begin
      case (ss)
        4'h0: r = {1'b0, ~aa};        4'h1: r = {1'b0, ~(aa | bb)};
        4'h2: r = {1'b0, ~aa & bb};   4'h3: r = 17'h0;
        4'h4: r = {1'b0, ~(aa & bb)}; 4'h5: r = {1'b0, ~bb};
        4'h6: r = {1'b0, aa ^ bb};    4'h7: r = {1'b0, aa & ~bb};
        4'h8: r = {1'b0, ~aa | bb};   4'h9: r = {1'b0, ~(aa ^ bb)};
        4'hA: r = {1'b0, bb};         4'hB: r = {1'b0, aa & bb};
        4'hC: r = 17'h0FFFF;          4'hD: r = {1'b0, aa | ~bb};
        4'hE: r = {1'b0, aa | bb};    default: r = {1'b0, aa};
      endcase
    end
    return r;
  endfunction

  // One complete transaction on the 16-bit instance; operands are scrambled
  // right after acceptance to show they are not re-sampled.
  task automatic run16(input logic mm, input logic [3:0] ss, input logic [15:0] aa,
                       input logic [15:0] bb, input logic cc, input logic early,
                       output logic [15:0] ff, output logic co, output logic eq,
                       output int lat, output logic ir_after, output logic ov_after);
    @(negedge clk);
    a = aa; b = bb; s = ss; m = mm; c_in = cc; in_valid = 1'b1; out_ready = early;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = ~mm; c_in = ~cc;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ff = f; co = c_out; eq = a_eq_b;
    out_ready = 1'b1;
    @(negedge clk);
    ir_after = in_ready; ov_after = out_valid;
    out_ready = 1'b0;
  endtask

  task automatic run8(input logic [7:0] aa, input logic cc,
                      output logic [7:0] ff, output logic co, output int lat);
    @(negedge clk);
    a8 = aa; b8 = 8'h00; s8 = 4'b0000; m8 = 1'b0; c_in8 = cc; in_valid8 = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid8 = 1'b0; a8 = 8'h5A;
    while (!out_valid8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ff = f8; co = c_out8;
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  initial begin
    logic [15:0] rf;
    logic        rc, re, ir, ov, seen;
    logic [16:0] exp17;
    logic [7:0]  rf8;
    int          lat;

    vecs[0]  = '{1'b0, 4'b0000, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 4'b1001, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0110, 16'h1234, 16'h1234, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 4'b0110, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'b0110, 16'h5A5A, 16'hFFFF, 1'b1, 16'hA5A5, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'b0011, 16'h1234, 16'h5678, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 4'b1100, 16'h8001, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'b1111, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 4'b1100, 16'h1234, 16'h5678, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 4'b0011, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b1001, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'b1011, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'b0110, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'b0100, 16'h0F00, 16'h0300, 1'b0, 16'h1B00, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'b0000, 16'h00FF, 16'h0000, 1'b1, 16'hFF00, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; c_in = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; s8 = '0; m8 = 1'b0; c_in8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_f", f, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_a_eq_b", a_eq_b, 0);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      run16(vecs[i].m, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].cin, logic'(i % 2),
            rf, rc, re, lat, ir, ov);
      chk($sformatf("vec%0d_f", i), rf, vecs[i].ef);
      chk($sformatf("vec%0d_c_out", i), rc, vecs[i].ec);
      chk($sformatf("vec%0d_a_eq_b", i), re, vecs[i].eq);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_in_ready_after", i), ir, 1);
      chk($sformatf("vec%0d_out_valid_after", i), ov, 0);
    end

    // All 32 (m, s) pairs with random operands against the reference.
    for (int mm = 0; mm < 2; mm++) begin
      for (int ss = 0; ss < 16; ss++) begin
        logic [15:0] ra, rb;
        logic        rcin;
        ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom);
        exp17 = ref16(logic'(mm), 4'(ss), ra, rb, rcin);
        run16(logic'(mm), 4'(ss), ra, rb, rcin, 1'b0, rf, rc, re, lat, ir, ov);
        chk($sformatf("sweep_m%0d_s%0d_f", mm, ss), rf, exp17[15:0]);
        chk($sformatf("sweep_m%0d_s%0d_c_out", mm, ss), rc, exp17[16]);
        chk($sformatf("sweep_m%0d_s%0d_a_eq_b", mm, ss), re, &exp17[15:0]);
      end
    end

    // Backpressure: result held while new operands are offered and refused.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; s = 4'b1001; m = 1'b0; c_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, 4);
    chk("bp_f", f, 16'h3333);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); s = 4'b1100;
      @(negedge clk);
      chk($sformatf("bp%0d_out_valid", k), out_valid, 1);
      chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
      chk($sformatf("bp%0d_f", k), f, 16'h3333);
      chk($sformatf("bp%0d_c_out", k), c_out, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_f_held", f, 16'h3333);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("bp_no_queued_op", seen, 0);

    // Reset while slice 2 is being computed.
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; s = 4'b1001; m = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_f", f, 0);
    chk("abort_c_out", c_out, 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_discarded", seen, 0);

    // WIDTH=8 instance.
    run8(8'hC3, 1'b1, rf8, rc, lat);
    chk("w8_f", rf8, 8'hC4);
    chk("w8_c_out", rc, 0);
    chk("w8_latency", lat, 2);
    run8(8'hFF, 1'b1, rf8, rc, lat);
    chk("w8_wrap_f", rf8, 8'h00);
    chk("w8_wrap_c_out", rc, 1);
    chk("w8_wrap_a_eq_b", a_eq_b8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ula_74181_serial.md
# ula_74181_serial

Parametrised, multi-cycle successor to the 8-bit 74181-style ALU (`ula_8bits`). It computes the full 32-function 74181 set (16 arithmetic with carry-in, 16 logic) on WIDTH-bit operands, one 4-bit slice per clock, rippling the carry through a register. Operands enter through a valid/ready handshake and results leave through one. It sits between the register file and the result bus where a narrow, low-area datapath is preferred over a single-cycle wide one.

## Interface
- WIDTH, 16: operand and result width in bits. Must be a multiple of 4 and ≥ 4. N = WIDTH/4 is the slice count.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept operands.
- a, b  in  WIDTH  operands.
- s  in  4  function select.
- m  in  1  mode: 0 = arithmetic, 1 = logic.
- c_in  in  1  carry-in, active-high (1 adds one).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- f  out  WIDTH  result.
- c_out  out  1  carry-out, active-high.
- a_eq_b  out  1  high when f is all ones (74181 A=B semantics).

## Operation
- FSM states: IDLE → CALC → DONE → IDLE.
- IDLE: in_ready=1. When in_valid && in_ready, latch a, b, s, m, c_in; set the carry register to c_in and the slice index to 0; go to CALC.
- CALC: each cycle, compute slice index k (bits 4k+3:4k) from the latched operands and the carry register, store the result into the accumulator slice, and update the carry register. After slice N−1, load f, c_out and a_eq_b from the accumulator and go to DONE.
- DONE: out_valid=1. When out_ready is high, go to IDLE.
- Arithmetic functions (m=0). F = expression + c_in, modulo 2^WIDTH. "−1" means adding all ones. c_out is bit WIDTH of the (WIDTH+1)-bit sum:
  - 0000 A; 0001 A|B; 0010 A|~B; 0011 −1
  - 0100 A+(A&~B); 0101 (A|B)+(A&~B); 0110 A−B−1; 0111 (A&~B)−1
  - 1000 A+(A&B); 1001 A+B; 1010 (A|~B)+(A&B); 1011 (A&B)−1
  - 1100 A+A; 1101 (A|B)+A; 1110 (A|~B)+A; 1111 A−1
- Logic functions (m=1), bitwise. c_in is ignored and c_out=0:
  - 0000 ~A; 0001 ~(A|B); 0010 ~A&B; 0011 0
  - 0100 ~(A&B); 0101 ~B; 0110 A^B; 0111 A&~B
  - 1000 ~A|B; 1001 ~(A^B); 1010 B; 1011 A&B
  - 1100 all ones; 1101 A|~B; 1110 A|B; 1111 A
- The result must equal the single-cycle WIDTH-bit evaluation of the same function bit-for-bit, including c_out.
- a_eq_b = (f == all ones), in both modes.

## Timing
- Reset (rst_n low at a rising edge): state IDLE; in_ready=1; out_valid=0; f=0; c_out=0; a_eq_b=0; internal registers cleared.
- Reset while in CALC or DONE aborts the operation. No result is emitted, and operands captured before the reset are discarded.
- Latency: operands are accepted at edge E0. out_valid rises after edge E_N. With WIDTH=16, out_valid rises 4 cycles after acceptance.
- in_ready is 0 in CALC and DONE. in_valid in those states is ignored; nothing is queued.
- f, c_out and a_eq_b change only on entry to DONE. They hold their value through DONE and afterwards, until the next DONE entry or reset.
- Backpressure: out_valid stays high and the outputs stay stable for as long as out_ready is low.
- When out_valid && out_ready at an edge, the next cycle is IDLE with in_ready=1. Minimum throughput is one operation per N+2 cycles.
- If out_ready is already high when DONE is entered, the result is consumed at the next edge.
- Operand inputs may change after E0 without affecting the operation in flight.

## Test plan
- WIDTH=16, m=0, s=0000, a=0xFFFF, c_in=1 → f=0x0000, c_out=1, a_eq_b=0; out_valid exactly 4 cycles after acceptance.
- WIDTH=16, m=0, s=1001, a=0x00FF, b=0x0001, c_in=0 → f=0x0100, c_out=0. This checks carry across slice boundaries.
- WIDTH=16, m=0, s=0110, a=b=0x1234, c_in=0 → f=0xFFFF, a_eq_b=1, c_out=0. The same inputs with c_in=1 → f=0x0000, c_out=1, a_eq_b=0.
- WIDTH=16, m=1, s=0110, a=0x5A5A, b=0xFFFF, c_in=1 → f=0xA5A5, c_out=0. Then sweep all 32 (m, s) pairs with random operands and compare against a single-cycle reference model.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands → f, c_out and out_valid stay stable, in_ready=0, and the new operands are never accepted. On release, in_ready=1 in the following cycle.
- Drive rst_n=0 for one edge during CALC (slice 2) → the next cycle shows IDLE with in_ready=1, out_valid=0, f=0. A WIDTH=8 instance with a=0xC3, s=0000, m=0, c_in=1 → f=0xC4, c_out=0, latency 2.
